// File: rtl/digit_serial_adder_pkg.sv
// dsa_pkg: FSM state encoding and default geometry shared by the digit-serial adder.
package dsa_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int DSA_WIDTH = 16;
    localparam int DSA_DIGIT = 4;
endpackage

// File: rtl/digit_adder.sv
// digit_adder: combinational DIGIT-bit ripple adder with carry in/out.
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co
);
    assign {co, s} = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, ci};
endmodule

// File: rtl/digit_serial_adder.sv
// digit_serial_adder: adds two WIDTH-bit operands DIGIT bits per clock.
// Define DIGIT_SERIAL_ADDER_SUB_EN to add a 'sub' port computing a - b.
module digit_serial_adder
    import dsa_pkg::*;
#(
    parameter int WIDTH = DSA_WIDTH,
    parameter int DIGIT = DSA_DIGIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);

    if (DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_bad_geometry
        $error("digit_serial_adder: WIDTH must be a multiple of DIGIT");
    end

    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt;
    logic [WIDTH-1:0]       sa, sb, acc;
    logic                   carry;
    logic [DIGIT-1:0]       ds;
    logic                   dco;
    logic [WIDTH+DIGIT-1:0] cat;
    logic [WIDTH-1:0]       b_in;
    logic                   c_in;
    logic                   accept, last;

`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    // Subtraction is a + ~b + 1; cin is ignored so cout reads as "no borrow".
    assign b_in = sub ? ~b : b;
    assign c_in = sub ? 1'b1 : cin;
`else
    assign b_in = b;
    assign c_in = cin;
`endif

    assign accept = start && state != RUN;
    assign last   = cnt == CW'(N - 1);
    assign cat    = {ds, acc};

    digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
        .a (sa[DIGIT-1:0]),
        .b (sb[DIGIT-1:0]),
        .ci(carry),
        .s (ds),
        .co(dco)
    );

    always_comb begin
        state_nxt = state;
        busy      = state == RUN;
        done      = state == DONE;
        if (state == RUN)
            state_nxt = last ? DONE : RUN;
        else
            state_nxt = start ? RUN : IDLE;
    end

    // Digits enter acc from the MSB end; sum is only written on the final digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            sa    <= '0;
            sb    <= '0;
            acc   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                sa    <= a;
                sb    <= b_in;
                carry <= c_in;
                acc   <= '0;
                cnt   <= '0;
            end else if (state == RUN) begin
                sa    <= sa >> DIGIT;
                sb    <= sb >> DIGIT;
                carry <= dco;
                acc   <= cat[WIDTH+DIGIT-1:DIGIT];
                cnt   <= cnt + 1'b1;
                if (last) begin
                    sum  <= cat[WIDTH+DIGIT-1:DIGIT];
                    cout <= dco;
                end
            end
        end
    end
endmodule

// File: doc/digit_serial_adder.md
DIGIT_SERIAL_ADDER -- requirements
Module: digit_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have parameter DIGIT, default 4, bits added per clock; WIDTH SHALL be a multiple of DIGIT (elaboration error otherwise).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port start  input  1  request; samples a, b, cin when accepted.
REQ-006 SHALL have port a  input  WIDTH  operand A.
REQ-007 SHALL have port b  input  WIDTH  operand B.
REQ-008 SHALL have port cin  input  1  carry-in.
REQ-009 SHALL have port busy  output  1  high while digits are being processed.
REQ-010 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-011 SHALL have port sum  output  WIDTH  result, held until next accepted start.
REQ-012 SHALL have port cout  output  1  carry-out of bit WIDTH-1, held with sum.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
- IDLE: start=1 -> capture a, b, cin, clear digit counter -> RUN.
- RUN: N = WIDTH/DIGIT cycles; after N-th digit -> DONE.
- DONE: done=1 for exactly this cycle; start=1 -> capture, RUN (back-to-back); else -> IDLE.
REQ-014 Each RUN cycle SHALL add the lowest DIGIT bits of the A and B shift registers plus the carry register, shift the DIGIT-bit result into sum from the MSB end, shift A/B right by DIGIT, and register carry-out.
REQ-015 Latency SHALL be N+1 clocks from the edge sampling start=1 to the edge where done=1 (16/4: 5 clocks).
REQ-016 Final {cout, sum} SHALL equal a + b + cin (WIDTH+1 bits, no truncation of carry).
REQ-017 busy SHALL be 1 exactly in RUN; start while busy SHALL be ignored; in-flight operands SHALL not change.
REQ-018 sum/cout SHALL be stable between done pulses; partial results SHALL never appear on sum (shift into an internal register, copy to sum on the RUN->DONE transition).
REQ-019 DIGIT = WIDTH SHALL work (N=1, latency 2); DIGIT = 1 SHALL work (N=WIDTH).

Reset
REQ-020 rst_n low SHALL asynchronously force IDLE, busy=0, done=0, sum=0, cout=0, counter/shift/carry registers=0.
REQ-021 Reset mid-RUN SHALL abort; no done pulse SHALL follow; first start after release SHALL behave as from power-up.

Configuration
REQ-022 Macro DIGIT_SERIAL_ADDER_SUB_EN defined: SHALL add port sub  input  1, sampled with start; sub=1 computes a + ~b + 1 (cin ignored), cout=1 means no borrow.
REQ-023 Macro undefined: port sub SHALL not exist; behaviour per REQ-016 only.

Structure
REQ-024 Package dsa_pkg SHALL hold the FSM state enum and the default WIDTH/DIGIT constants.
REQ-025 Combinational DIGIT-bit ripple adder SHALL be sub-module digit_adder (a, b, ci -> s, co), instantiated once.

Verification
REQ-026 WIDTH=16, DIGIT=4: a=16'h0001, b=16'hFFFF, cin=0, start pulse -> done 5 clocks later, sum=16'h0000, cout=1, busy high for 4 clocks.
REQ-027 WIDTH=4, DIGIT=1: all 512 (a,b,cin) combinations sequentially -> each {cout,sum} equals a+b+cin; $monitor-style log per result.
REQ-028 start held high continuously with changing a/b -> results match operands sampled only at IDLE/DONE acceptance; done pulses every N+1 clocks.
REQ-029 rst_n low at RUN cycle 2, released 3 clocks later -> sum=0, cout=0, no done; next op a=16'h1234, b=16'h4321, cin=1 -> sum=16'h5556, cout=0.
REQ-030 SUB_EN defined: a=16'd5, b=16'd7, sub=1 -> sum=16'hFFFE, cout=0; a=7, b=5, sub=1 -> sum=16'h0002, cout=1.
